// File: rtl/rv32_writeback_arbiter_pkg.sv
// Shared RV32 writeback types: register id, data word and the FIFO entry.
package rv32_types;

    localparam int unsigned RV32_NUM_REGS = 32;

    typedef logic [4:0]  rv_reg_id_t;
    typedef logic [31:0] rv32_word;

    typedef struct packed {
        rv_reg_id_t rd;
        rv32_word   data;
    } wb_entry_t;

endpackage

// File: rtl/rv32_writeback_arbiter_fifo.sv
// Small synchronous FIFO of writeback entries. Pointers carry one extra wrap
// bit so that full and empty can be told apart when the indices are equal.
module rv32_wb_fifo
    import rv32_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t       mem_q [DEPTH];
    wb_entry_t       mem_d [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            do_push;
    logic            do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next-state for storage and pointers.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer and storage registers; reset discards all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/rv32_writeback_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the register file write
// port with mem priority bounded by an ALU starvation counter.
// Optional busy-register scoreboard enabled by RV32_WB_SCOREBOARD_EN.
module rv32_writeback_arbiter
    import rv32_types::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  rv_reg_id_t               alu_rd,
    input  rv32_word                 alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  rv_reg_id_t               mem_rd,
    input  rv32_word                 mem_data,
`ifdef RV32_WB_SCOREBOARD_EN
    input  logic                     issue_valid,
    input  rv_reg_id_t               issue_rd,
    output logic [RV32_NUM_REGS-1:0] busy,
`endif
    output logic                     rf_write,
    output rv_reg_id_t               rf_rw,
    output rv32_word                 rf_d,
    output logic                     wb_idle
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic      alu_full, alu_empty, mem_full, mem_empty;
    logic      alu_pop, mem_pop, any_pop;
    wb_entry_t alu_head, mem_head, pop_entry;
    logic [SW-1:0] starve_q, starve_d;
    logic       rf_write_q, rf_write_d;
    rv_reg_id_t rf_rw_q, rf_rw_d;
    rv32_word   rf_d_q, rf_d_d;

    assign alu_ready = !alu_full;
    assign mem_ready = !mem_full;

    rv32_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (alu_valid && alu_ready),
        .push_data ('{rd: alu_rd, data: alu_data}),
        .pop       (alu_pop),
        .full      (alu_full),
        .empty     (alu_empty),
        .head      (alu_head)
    );

    rv32_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mem_valid && mem_ready),
        .push_data ('{rd: mem_rd, data: mem_data}),
        .pop       (mem_pop),
        .full      (mem_full),
        .empty     (mem_empty),
        .head      (mem_head)
    );

    // Arbitration on FIFO heads, starvation tracking and output next-state.
    always_comb begin
        alu_pop    = !alu_empty && (mem_empty || (starve_q == SW'(STARVE_LIMIT)));
        mem_pop    = !mem_empty && !alu_pop;
        any_pop    = alu_pop || mem_pop;
        pop_entry  = alu_pop ? alu_head : mem_head;

        starve_d   = starve_q;
        if (alu_pop) begin
            starve_d = '0;
        end else if (!alu_empty && mem_pop && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end

        rf_write_d = any_pop && (pop_entry.rd != '0);
        rf_rw_d    = rf_rw_q;
        rf_d_d     = rf_d_q;
        if (any_pop) begin
            rf_rw_d = pop_entry.rd;
            rf_d_d  = pop_entry.data;
        end
    end

    // Registered write port and starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q   <= '0;
            rf_write_q <= 1'b0;
            rf_rw_q    <= '0;
            rf_d_q     <= '0;
        end else begin
            starve_q   <= starve_d;
            rf_write_q <= rf_write_d;
            rf_rw_q    <= rf_rw_d;
            rf_d_q     <= rf_d_d;
        end
    end

    assign rf_write = rf_write_q;
    assign rf_rw    = rf_rw_q;
    assign rf_d     = rf_d_q;
    assign wb_idle  = alu_empty && mem_empty && !rf_write_q;

`ifdef RV32_WB_SCOREBOARD_EN
    logic [RV32_NUM_REGS-1:0] busy_q, busy_d;

    // Busy bits: clear on a writing pop, set on issue; set applied last so it wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_write_d) begin
            busy_d[pop_entry.rd] = 1'b0;
        end
        if (issue_valid) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`endif

endmodule

// File: tb/tb_rv32_writeback_arbiter.sv
// Scoreboard bench for rv32_writeback_arbiter: a cycle model predicts each
// register file write, which is queued and popped when the DUT writes.
module tb_rv32_writeback_arbiter;
    import rv32_types::*;

    localparam int unsigned FIFO_DEPTH   = 2;
    localparam int unsigned STARVE_LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_valid, mem_valid;
    logic       alu_ready, mem_ready;
    rv_reg_id_t alu_rd, mem_rd;
    rv32_word   alu_data, mem_data;
    logic       rf_write;
    rv_reg_id_t rf_rw;
    rv32_word   rf_d;
    logic       wb_idle;
`ifdef RV32_WB_SCOREBOARD_EN
    logic       issue_valid = 1'b0;
    rv_reg_id_t issue_rd = '0;
    logic [31:0] busy;
`endif

    rv32_writeback_arbiter #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
`ifdef RV32_WB_SCOREBOARD_EN
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
`endif
        .rf_write  (rf_write),
        .rf_rw     (rf_rw),
        .rf_d      (rf_d),
        .wb_idle   (wb_idle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    wb_entry_t mq_alu[$];
    wb_entry_t mq_mem[$];
    wb_entry_t exp_q[$];
    logic [3:0] obs_src[$];
    int  m_starve = 0;
    bit  m_write = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check #1 after.
    task automatic step(input bit av, input rv_reg_id_t ard, input rv32_word ad,
                        input bit mv, input rv_reg_id_t mrd, input rv32_word md);
        bit a_rdy, m_rdy, a_pop, m_pop;
        wb_entry_t e;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        a_rdy = (mq_alu.size() < FIFO_DEPTH);
        m_rdy = (mq_mem.size() < FIFO_DEPTH);
        check_eq("alu_ready", 32'(alu_ready), 32'(a_rdy));
        check_eq("mem_ready", 32'(mem_ready), 32'(m_rdy));
        @(posedge clk);
        a_pop = (mq_alu.size() > 0) && ((mq_mem.size() == 0) || (m_starve == STARVE_LIMIT));
        m_pop = (mq_mem.size() > 0) && !a_pop;
        e = '0;
        if (a_pop) begin
            e = mq_alu.pop_front();
            m_starve = 0;
        end else if (mq_alu.size() > 0 && m_pop && m_starve < STARVE_LIMIT) begin
            m_starve++;
        end
        if (m_pop) e = mq_mem.pop_front();
        m_write = (a_pop || m_pop) && (e.rd != 0);
        if (m_write) exp_q.push_back(e);
        if (av && a_rdy) mq_alu.push_back('{rd: ard, data: ad});
        if (mv && m_rdy) mq_mem.push_back('{rd: mrd, data: md});
        #1;
        check_eq("rf_write", 32'(rf_write), 32'(m_write));
        if (rf_write) begin
            obs_src.push_back(rf_d[31:28]);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("rf_rw", 32'(rf_rw), 32'(e.rd));
                check_eq("rf_d", rf_d, e.data);
            end else begin
                check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end
        end
        check_eq("wb_idle", 32'(wb_idle),
                 32'(mq_alu.size() == 0 && mq_mem.size() == 0 && !m_write));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
    endtask

    task automatic model_reset();
        mq_alu.delete(); mq_mem.delete(); exp_q.delete();
        m_starve = 0; m_write = 0;
    endtask

    initial begin
        logic [3:0] pat [10];
        pat = '{4'hB, 4'hB, 4'hB, 4'hB, 4'hA, 4'hB, 4'hB, 4'hB, 4'hB, 4'hA};
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0;
        #12;
        check_eq("rst_rf_write", 32'(rf_write), 32'd0);
        check_eq("rst_rf_rw", 32'(rf_rw), 32'd0);
        check_eq("rst_rf_d", rf_d, 32'd0);
        check_eq("rst_alu_ready", 32'(alu_ready), 32'd1);
        check_eq("rst_mem_ready", 32'(mem_ready), 32'd1);
        check_eq("rst_wb_idle", 32'(wb_idle), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle(2);

        // Single ALU write, one-cycle latency after the push edge.
        step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
        check_eq("t2_no_write_yet", 32'(rf_write), 32'd0);
        idle(1);
        check_eq("t2_write", 32'(rf_write), 32'd1);
        check_eq("t2_rd", 32'(rf_rw), 32'd5);
        check_eq("t2_data", rf_d, 32'hDEADBEEF);
        idle(1);
        check_eq("t2_write_drop", 32'(rf_write), 32'd0);
        check_eq("t2_idle", 32'(wb_idle), 32'd1);

        // Both channels streaming: mem x4 then alu, order kept per channel.
        obs_src.delete();
        for (int k = 0; k < 16; k++)
            step(1, 5'(1 + k % 31), 32'hA000_0000 | k, 1, 5'(2 + k % 29), 32'hB000_0000 | k);
        idle(8);
        check_eq("t3_pops", 32'(obs_src.size() >= 10), 32'd1);
        for (int i = 0; i < 10 && i < obs_src.size(); i++)
            check_eq($sformatf("t3_src%0d", i), 32'(obs_src[i]), 32'(pat[i]));
        check_eq("t3_drained", 32'(exp_q.size()), 32'd0);

        // rd=0 entry consumed silently.
        step(1, 5'd0, 32'h1234_5678, 0, '0, '0);
        idle(1);
        check_eq("t4_no_write", 32'(rf_write), 32'd0);
        idle(1);
        check_eq("t4_idle", 32'(wb_idle), 32'd1);

        // Fill ALU FIFO behind mem traffic, then reset mid-stream.
        step(1, 5'd9, 32'hA000_0100, 1, 5'd10, 32'hB000_0100);
        step(1, 5'd11, 32'hA000_0101, 1, 5'd12, 32'hB000_0101);
        check_eq("t5_alu_full", 32'(alu_ready), 32'd0);
        check_eq("t5_writing", 32'(rf_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_async_write", 32'(rf_write), 32'd0);
        check_eq("t5_async_rw", 32'(rf_rw), 32'd0);
        check_eq("t5_async_d", rf_d, 32'd0);
        check_eq("t5_alu_ready", 32'(alu_ready), 32'd1);
        model_reset();
        alu_valid = 0; mem_valid = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle(3);
        check_eq("t5_empty_idle", 32'(wb_idle), 32'd1);

`ifdef RV32_WB_SCOREBOARD_EN
        // Busy scoreboard: set on issue, clear on pop, set wins on collision.
        issue_valid = 1; issue_rd = 5'd7;
        idle(1);
        issue_valid = 0;
        check_eq("sb_set", 32'(busy[7]), 32'd1);
        step(1, 5'd7, 32'hA000_0777, 0, '0, '0);
        check_eq("sb_hold", 32'(busy[7]), 32'd1);
        idle(1);
        check_eq("sb_clear", 32'(busy[7]), 32'd0);
        step(1, 5'd7, 32'hA000_0778, 0, '0, '0);
        issue_valid = 1; issue_rd = 5'd7;
        idle(1);
        issue_valid = 0;
        check_eq("sb_set_wins", 32'(busy[7]), 32'd1);
        issue_valid = 1; issue_rd = 5'd0;
        idle(1);
        issue_valid = 0;
        check_eq("sb_x0", 32'(busy[0]), 32'd0);
`endif

        idle(2);
        check_eq("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
